// File: rtl/rsa_pkg.sv
// Shared types for the RSA key-setup datapath: word types, Euclid FSM states, default width.
package rsa_pkg;

    localparam int unsigned WORD_WIDTH_DEF = 32;

    typedef logic        [WORD_WIDTH_DEF-1:0] word_t;
    typedef logic signed [WORD_WIDTH_DEF-1:0] sword_t;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DIV,
        UPDATE,
        DONE
    } euclid_state_e;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; quotient is valid WORD_WIDTH cycles after start.
// Divisor is non-zero and both operands are below 2^(WORD_WIDTH-1) whenever start_i is raised.
module seq_divider
    import rsa_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [WORD_WIDTH-1:0] dividend_i,
    input  logic [WORD_WIDTH-1:0] divisor_i,
    output logic                  valid_o,
    output logic [WORD_WIDTH-1:0] quotient_o
);

    localparam int unsigned W  = WORD_WIDTH;
    localparam int unsigned CW = $clog2(WORD_WIDTH + 1);

    logic [W-1:0]  rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d;

    logic [W-1:0]  step_rem_in, step_quo_in, step_dvs, step_rem, step_quo;
    logic [W:0]    rem_sh;
    logic          q_bit;

    // One restoring step; the start cycle already performs the first step on the fresh operands.
    always_comb begin
        step_rem_in = rem_q;
        step_quo_in = quo_q;
        step_dvs    = dvs_q;
        if (start_i) begin
            step_rem_in = '0;
            step_quo_in = dividend_i;
            step_dvs    = divisor_i;
        end
        rem_sh = {step_rem_in, step_quo_in[W-1]};
        q_bit  = (rem_sh >= {1'b0, step_dvs});
        step_rem = q_bit ? W'(rem_sh - {1'b0, step_dvs}) : W'(rem_sh);
        step_quo = {step_quo_in[W-2:0], q_bit};
    end

    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        if (start_i) begin
            rem_d = step_rem;
            quo_d = step_quo;
            dvs_d = divisor_i;
            cnt_d = CW'(W - 1);
        end else if (cnt_q != '0) begin
            rem_d   = step_rem;
            quo_d   = step_quo;
            cnt_d   = cnt_q - CW'(1);
            valid_d = (cnt_q == CW'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign valid_o    = valid_q;
    assign quotient_o = quo_q;

endmodule

// File: rtl/extended_euclid.sv
// Sequential extended Euclid: gcd(e, n) and Bezout coefficient s with e*s == gcd (mod n).
// Feeds modular_inverse; one CHECK + WORD_WIDTH DIV + one UPDATE cycle per division step.
module extended_euclid
    import rsa_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_i,
    input  logic [WORD_WIDTH-1:0]        e_i,
    input  logic [WORD_WIDTH-1:0]        n_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic signed [WORD_WIDTH-1:0] gcd_o,
    output logic signed [WORD_WIDTH-1:0] coeff_o,
    output logic                         invalid_o
);

    localparam int unsigned W = WORD_WIDTH;

    euclid_state_e state_q, state_d;

    logic        [W-1:0]   old_r_q, old_r_d, r_q, r_d;
    logic signed [W-1:0]   old_s_q, old_s_d, s_q, s_d;
    logic                  inv_q, inv_d;

    logic                  busy_q, busy_d, done_q, done_d, invalid_q, invalid_d;
    logic signed [W-1:0]   gcd_q, gcd_d, coeff_q, coeff_d;

    logic                  div_start_c;
    logic                  div_valid;
    logic        [W-1:0]   quo;
    logic        [W-1:0]   qr_c;
    logic signed [2*W-1:0] qs_c;

    seq_divider #(.WORD_WIDTH(W)) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (div_start_c),
        .dividend_i (old_r_q),
        .divisor_i  (r_q),
        .valid_o    (div_valid),
        .quotient_o (quo)
    );

    // q*r never exceeds old_r, so W bits suffice; q*s needs the double-width signed product.
    assign qr_c = W'(quo * r_q);
    assign qs_c = $signed({{W{1'b0}}, quo}) * $signed({{W{s_q[W-1]}}, s_q});

    always_comb begin
        state_d     = state_q;
        old_r_d     = old_r_q;
        r_d         = r_q;
        old_s_d     = old_s_q;
        s_d         = s_q;
        inv_d       = inv_q;
        div_start_c = 1'b0;
        gcd_d       = gcd_q;
        coeff_d     = coeff_q;
        invalid_d   = invalid_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = CHECK;
                    old_r_d = e_i;
                    r_d     = n_i;
                    old_s_d = W'(1);
                    s_d     = '0;
                    inv_d   = (n_i == '0) || e_i[W-1] || n_i[W-1];
                end
            end
            CHECK: begin
                if (inv_q || (r_q == '0)) begin
                    state_d = DONE;
                end else begin
                    state_d     = DIV;
                    div_start_c = 1'b1;
                end
            end
            DIV: begin
                if (div_valid) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                old_r_d = r_q;
                r_d     = old_r_q - qr_c;
                old_s_d = s_q;
                s_d     = old_s_q - $signed(qs_c[W-1:0]);
                state_d = CHECK;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so done_o coincides with the DONE state.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        if (state_d == DONE) begin
            gcd_d     = inv_q ? '0 : $signed(old_r_q);
            coeff_d   = inv_q ? '0 : old_s_q;
            invalid_d = inv_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            old_r_q   <= '0;
            r_q       <= '0;
            old_s_q   <= '0;
            s_q       <= '0;
            inv_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            gcd_q     <= '0;
            coeff_q   <= '0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            old_r_q   <= old_r_d;
            r_q       <= r_d;
            old_s_q   <= old_s_d;
            s_q       <= s_d;
            inv_q     <= inv_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            gcd_q     <= gcd_d;
            coeff_q   <= coeff_d;
            invalid_q <= invalid_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign gcd_o     = gcd_q;
    assign coeff_o   = coeff_q;
    assign invalid_o = invalid_q;

endmodule

// File: tb/tb_extended_euclid.sv
// Directed-vector bench for extended_euclid with hand-computed gcd, coefficient and latency.
module tb_extended_euclid;
    import rsa_pkg::*;

    logic   clk     = 1'b0;
    logic   rst_n   = 1'b0;
    logic   start_i = 1'b0;
    word_t  e_i     = '0;
    word_t  n_i     = '0;
    logic   busy_o, done_o, invalid_o;
    sword_t gcd_o, coeff_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    extended_euclid #(.WORD_WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start_i),
        .e_i       (e_i),
        .n_i       (n_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .gcd_o     (gcd_o),
        .coeff_o   (coeff_o),
        .invalid_o (invalid_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Start one job, measure cycles from the start edge to done_o, then check the results.
    task automatic run_job(input string tag, input word_t e, input word_t n, input int lat,
                           input logic [31:0] g, input logic [31:0] c, input logic inv);
        int cyc;
        @(negedge clk);
        e_i = e; n_i = n; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        cyc = 1;
        chk({tag, ".busy1"}, 32'(busy_o), 32'd1);
        while (!done_o && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, ".lat"}, done_o ? 32'(cyc) : 32'd0, 32'(lat));
        chk({tag, ".gcd"}, gcd_o, g);
        chk({tag, ".coeff"}, coeff_o, c);
        chk({tag, ".inv"}, 32'(invalid_o), 32'(inv));
        @(posedge clk); #1;
        chk({tag, ".pulse"}, 32'(done_o), 32'd0);
        chk({tag, ".idle"}, 32'(busy_o), 32'd0);
        chk({tag, ".hold"}, gcd_o, g);
    endtask

    initial begin
        int cyc;
        int busy_ok;
        int dones;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst.busy", 32'(busy_o), 32'd0);
        chk("rst.done", 32'(done_o), 32'd0);
        chk("rst.gcd", gcd_o, 32'd0);
        chk("rst.coeff", coeff_o, 32'd0);
        chk("rst.inv", 32'(invalid_o), 32'd0);

        run_job("e3n7",     32'd3,  32'd7,    104, 32'd1, -32'sd2,   1'b0);
        run_job("e5n7",     32'd5,  32'd7,    138, 32'd1, 32'd3,     1'b0);
        run_job("e6n9",     32'd6,  32'd9,    104, 32'd3, -32'sd1,   1'b0);
        run_job("e0n7",     32'd0,  32'd7,    36,  32'd7, 32'd0,     1'b0);
        run_job("e10n7",    32'd10, 32'd7,    104, 32'd1, -32'sd2,   1'b0);
        run_job("e7n7",     32'd7,  32'd7,    36,  32'd7, 32'd0,     1'b0);
        run_job("e17n3120", 32'd17, 32'd3120, 172, 32'd1, -32'sd367, 1'b0);
        run_job("n0",       32'd5,  32'd0,    2,   32'd0, 32'd0,     1'b1);
        run_job("emsb",     32'h8000_0001, 32'd7, 2, 32'd0, 32'd0,  1'b1);
        run_job("nmsb",     32'd3,  32'h8000_0000, 2, 32'd0, 32'd0, 1'b1);
        run_job("after_inv", 32'd5, 32'd7,    138, 32'd1, 32'd3,     1'b0);

        // start held high with changing operands, including through the done cycle
        @(negedge clk);
        e_i = 32'd3; n_i = 32'd7; start_i = 1'b1;
        @(posedge clk); #1;
        e_i = 32'd6; n_i = 32'd9;
        cyc = 1;
        busy_ok = 1;
        while (!done_o && cyc < 400) begin
            if (!busy_o) busy_ok = 0;
            @(posedge clk); #1;
            cyc++;
        end
        chk("hold.lat", done_o ? 32'(cyc) : 32'd0, 32'd104);
        chk("hold.busy", 32'(busy_ok), 32'd1);
        chk("hold.gcd", gcd_o, 32'd1);
        chk("hold.coeff", coeff_o, -32'sd2);
        @(posedge clk); #1;
        start_i = 1'b0;
        chk("hold.ignored", 32'(busy_o), 32'd0);

        // asynchronous reset in the middle of the first division
        @(negedge clk);
        e_i = 32'd3; n_i = 32'd7; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort.busy", 32'(busy_o), 32'd0);
        chk("abort.gcd", gcd_o, 32'd0);
        chk("abort.coeff", coeff_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk); #1;
            if (done_o || busy_o) dones++;
        end
        chk("abort.quiet", 32'(dones), 32'd0);
        run_job("post_rst", 32'd3, 32'd7, 104, 32'd1, -32'sd2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
